// File: rtl/rat_recovery_ctrl_if.sv
`default_nettype none
// ============================================================================
// rat_recovery_ctrl_if : ROB / rename-table side bundle of the RAT recovery sequencer
// Rev 1.0
// ============================================================================
interface rat_recovery_ctrl_if #(
  parameter int ROBID_W     = 7,
  parameter int LREG_LENGTH = 5,
  parameter int PREG_LENGTH = 6
);
  logic                   flush_valid;
  logic [ROBID_W-1:0]     flush_robid;
  logic                   flush_self;
  logic [ROBID_W-1:0]     rob_head_ptr;

  logic [ROBID_W-1:0]     walk_rdptr0;
  logic [ROBID_W-1:0]     walk_rdptr1;
  logic                   walk_rd0_need_to_wb;
  logic                   walk_rd1_need_to_wb;
  logic [LREG_LENGTH-1:0] walk_rd0_lrd;
  logic [LREG_LENGTH-1:0] walk_rd1_lrd;
  logic [PREG_LENGTH-1:0] walk_rd0_prd;
  logic [PREG_LENGTH-1:0] walk_rd1_prd;

  logic [1:0]             rob_state;
  logic                   rob_walk0_valid;
  logic                   rob_walk1_valid;
  logic [LREG_LENGTH-1:0] rob_walk0_lrd;
  logic [LREG_LENGTH-1:0] rob_walk1_lrd;
  logic [PREG_LENGTH-1:0] rob_walk0_prd;
  logic [PREG_LENGTH-1:0] rob_walk1_prd;
  logic                   rename_stall;
  logic                   commit_block;
  logic                   recovery_done;

  modport master (
    output flush_valid, flush_robid, flush_self, rob_head_ptr,
    output walk_rd0_need_to_wb, walk_rd1_need_to_wb,
    output walk_rd0_lrd, walk_rd1_lrd, walk_rd0_prd, walk_rd1_prd,
    input  walk_rdptr0, walk_rdptr1, rob_state,
    input  rob_walk0_valid, rob_walk1_valid, rob_walk0_lrd, rob_walk1_lrd,
    input  rob_walk0_prd, rob_walk1_prd, rename_stall, commit_block, recovery_done
  );

  modport slave (
    input  flush_valid, flush_robid, flush_self, rob_head_ptr,
    input  walk_rd0_need_to_wb, walk_rd1_need_to_wb,
    input  walk_rd0_lrd, walk_rd1_lrd, walk_rd0_prd, walk_rd1_prd,
    output walk_rdptr0, walk_rdptr1, rob_state,
    output rob_walk0_valid, rob_walk1_valid, rob_walk0_lrd, rob_walk1_lrd,
    output rob_walk0_prd, rob_walk1_prd, rename_stall, commit_block, recovery_done
  );
endinterface
`default_nettype wire

// File: rtl/rat_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// rat_recovery_ctrl : flush-driven speculative RAT restore (overwrite, then ROB walk)
// Rev 1.0
// ============================================================================
module rat_recovery_ctrl #(
  parameter int ROB_DEPTH   = 64,
  parameter int ROBID_W     = 7,
  parameter int LREG_LENGTH = 5,
  parameter int PREG_LENGTH = 6
) (
  input  wire logic          clock,
  input  wire logic          reset_n,
  rat_recovery_ctrl_if.slave bus
);

  localparam logic [1:0] c_ST_IDLE = 2'b00;
  localparam logic [1:0] c_ST_OVW  = 2'b01;
  localparam logic [1:0] c_ST_WALK = 2'b10;

  typedef logic [ROBID_W-1:0] robid_t;

  generate
    if (ROBID_W != $clog2(ROB_DEPTH) + 1) begin : g_bad_robid_w
      $error("ROBID_W must equal log2(ROB_DEPTH)+1");
    end
  endgenerate

  logic [1:0] state_q, state_d;
  robid_t     tgt_robid_q, tgt_robid_d;
  logic       tgt_self_q, tgt_self_d;
  robid_t     walk_ptr_q, walk_ptr_d;
  robid_t     remaining_q, remaining_d;
  logic       recovery_done_q, recovery_done_d;

  robid_t     w_new_dist;
  robid_t     w_cur_dist;
  robid_t     w_step;
  logic       w_take_new;

  // Surviving entries between the commit head and the flush point.
  function automatic robid_t end_dist(robid_t f, logic s, robid_t h);
    return f + robid_t'(!s) - h;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= c_ST_IDLE;
      tgt_robid_q     <= '0;
      tgt_self_q      <= 1'b0;
      walk_ptr_q      <= '0;
      remaining_q     <= '0;
      recovery_done_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tgt_robid_q     <= tgt_robid_d;
      tgt_self_q      <= tgt_self_d;
      walk_ptr_q      <= walk_ptr_d;
      remaining_q     <= remaining_d;
      recovery_done_q <= recovery_done_d;
    end
  end

  always_comb begin
    w_new_dist  = end_dist(bus.flush_robid, bus.flush_self, bus.rob_head_ptr);
    w_cur_dist  = end_dist(tgt_robid_q, tgt_self_q, bus.rob_head_ptr);
    w_take_new  = (state_q == c_ST_IDLE) || (w_new_dist < w_cur_dist);
    w_step      = (remaining_q >= robid_t'(2)) ? robid_t'(2) : remaining_q;
    state_d     = state_q;
    tgt_robid_d = tgt_robid_q;
    tgt_self_d  = tgt_self_q;
    walk_ptr_d  = walk_ptr_q;
    remaining_d = remaining_q;
    case (state_q)
      c_ST_IDLE: ;
      c_ST_OVW: begin
        walk_ptr_d  = bus.rob_head_ptr;
        remaining_d = w_cur_dist;
        state_d     = (w_cur_dist == '0) ? c_ST_IDLE : c_ST_WALK;
      end
      c_ST_WALK: begin
        walk_ptr_d  = walk_ptr_q + w_step;
        remaining_d = remaining_q - w_step;
        if (remaining_q <= robid_t'(2)) state_d = c_ST_IDLE;
      end
      default: state_d = c_ST_IDLE;
    endcase
    // Any flush restarts at the overwrite: replayed mappings may be younger than the new target.
    if (bus.flush_valid) begin
      if (w_take_new) begin
        tgt_robid_d = bus.flush_robid;
        tgt_self_d  = bus.flush_self;
      end
      state_d = c_ST_OVW;
    end
    recovery_done_d = (state_q != c_ST_IDLE) && (state_d == c_ST_IDLE);
  end

  always_comb begin
    bus.rob_state       = state_q;
    bus.commit_block    = (state_q != c_ST_IDLE);
    bus.rename_stall    = bus.flush_valid | (state_q != c_ST_IDLE);
    bus.recovery_done   = recovery_done_q;
    bus.walk_rdptr0     = '0;
    bus.walk_rdptr1     = '0;
    bus.rob_walk0_valid = 1'b0;
    bus.rob_walk1_valid = 1'b0;
    bus.rob_walk0_lrd   = '0;
    bus.rob_walk1_lrd   = '0;
    bus.rob_walk0_prd   = '0;
    bus.rob_walk1_prd   = '0;
    if (state_q == c_ST_WALK) begin
      bus.walk_rdptr0     = walk_ptr_q;
      bus.walk_rdptr1     = walk_ptr_q + robid_t'(1);
      bus.rob_walk0_valid = (remaining_q >= robid_t'(1)) & bus.walk_rd0_need_to_wb;
      bus.rob_walk1_valid = (remaining_q >= robid_t'(2)) & bus.walk_rd1_need_to_wb;
      bus.rob_walk0_lrd   = bus.walk_rd0_lrd;
      bus.rob_walk1_lrd   = bus.walk_rd1_lrd;
      bus.rob_walk0_prd   = bus.walk_rd0_prd;
      bus.rob_walk1_prd   = bus.walk_rd1_prd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rat_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rat_recovery_ctrl : directed self-checking bench for rat_recovery_ctrl
// Rev 1.0
// ============================================================================
module tb_rat_recovery_ctrl;

  localparam int ROB_DEPTH   = 64;
  localparam int ROBID_W     = 7;
  localparam int LREG_LENGTH = 5;
  localparam int PREG_LENGTH = 6;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  rat_recovery_ctrl_if #(
    .ROBID_W    (ROBID_W),
    .LREG_LENGTH(LREG_LENGTH),
    .PREG_LENGTH(PREG_LENGTH)
  ) bus ();

  rat_recovery_ctrl #(
    .ROB_DEPTH  (ROB_DEPTH),
    .ROBID_W    (ROBID_W),
    .LREG_LENGTH(LREG_LENGTH),
    .PREG_LENGTH(PREG_LENGTH)
  ) u_dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  // ROB contents: every entry whose index ends in 2'b01 writes no register.
  function automatic logic need_of(logic [6:0] p);
    return p[1:0] != 2'b01;
  endfunction

  function automatic logic [5:0] prd_of(logic [6:0] p);
    return p[5:0] ^ 6'h2A;
  endfunction

  always_comb begin
    bus.walk_rd0_need_to_wb = need_of(bus.walk_rdptr0);
    bus.walk_rd1_need_to_wb = need_of(bus.walk_rdptr1);
    bus.walk_rd0_lrd        = bus.walk_rdptr0[4:0];
    bus.walk_rd1_lrd        = bus.walk_rdptr1[4:0];
    bus.walk_rd0_prd        = prd_of(bus.walk_rdptr0);
    bus.walk_rd1_prd        = prd_of(bus.walk_rdptr1);
  end

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    bus.flush_valid = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_flush(logic [6:0] robid, logic self_sq);
    bus.flush_valid = 1'b1;
    bus.flush_robid = robid;
    bus.flush_self  = self_sq;
  endtask

  task automatic check_quiet(string tag);
    check({tag, " state"},   32'(bus.rob_state), 32'd0);
    check({tag, " rdptr0"},  32'(bus.walk_rdptr0), 32'd0);
    check({tag, " rdptr1"},  32'(bus.walk_rdptr1), 32'd0);
    check({tag, " valids"},  32'({bus.rob_walk1_valid, bus.rob_walk0_valid}), 32'd0);
    check({tag, " lrd/prd"}, 32'({bus.rob_walk0_lrd, bus.rob_walk1_lrd,
                                  bus.rob_walk0_prd, bus.rob_walk1_prd}), 32'd0);
    check({tag, " stall"},   32'(bus.rename_stall), 32'd0);
    check({tag, " cblock"},  32'(bus.commit_block), 32'd0);
    check({tag, " done"},    32'(bus.recovery_done), 32'd0);
  endtask

  task automatic check_walk(string tag, logic [6:0] p0, int rem);
    logic [6:0] p1;
    p1 = p0 + 7'd1;
    check({tag, " state"},  32'(bus.rob_state), 32'd2);
    check({tag, " rdptr0"}, 32'(bus.walk_rdptr0), 32'(p0));
    check({tag, " rdptr1"}, 32'(bus.walk_rdptr1), 32'(p1));
    check({tag, " v0"},     32'(bus.rob_walk0_valid), 32'((rem >= 1) && need_of(p0)));
    check({tag, " v1"},     32'(bus.rob_walk1_valid), 32'((rem >= 2) && need_of(p1)));
    check({tag, " lrd0"},   32'(bus.rob_walk0_lrd), 32'(p0[4:0]));
    check({tag, " lrd1"},   32'(bus.rob_walk1_lrd), 32'(p1[4:0]));
    check({tag, " prd0"},   32'(bus.rob_walk0_prd), 32'(prd_of(p0)));
    check({tag, " prd1"},   32'(bus.rob_walk1_prd), 32'(prd_of(p1)));
    check({tag, " cblock"}, 32'(bus.commit_block), 32'd1);
    check({tag, " done"},   32'(bus.recovery_done), 32'd0);
  endtask

  // One full recovery with k surviving entries, k hand-computed by the caller.
  task automatic run_seq(string tag, logic [6:0] head, logic [6:0] robid, logic self_sq, int k);
    logic [6:0] p;
    int         rem;
    step();
    bus.rob_head_ptr = head;
    drive_flush(robid, self_sq);
    settle();
    check({tag, " T stall"},  32'(bus.rename_stall), 32'd1);
    check({tag, " T state"},  32'(bus.rob_state), 32'd0);
    step();
    settle();
    check({tag, " ovw state"},  32'(bus.rob_state), 32'd1);
    check({tag, " ovw valids"}, 32'({bus.rob_walk1_valid, bus.rob_walk0_valid}), 32'd0);
    check({tag, " ovw cblock"}, 32'(bus.commit_block), 32'd1);
    check({tag, " ovw done"},   32'(bus.recovery_done), 32'd0);
    p   = head;
    rem = k;
    while (rem > 0) begin
      step();
      settle();
      check_walk($sformatf("%s walk@%0h", tag, p), p, rem);
      p   = p + 7'd2;
      rem = (rem >= 2) ? rem - 2 : 0;
    end
    step();
    settle();
    check({tag, " end state"},  32'(bus.rob_state), 32'd0);
    check({tag, " end done"},   32'(bus.recovery_done), 32'd1);
    check({tag, " end cblock"}, 32'(bus.commit_block), 32'd0);
    step();
    settle();
    check({tag, " done pulse"}, 32'(bus.recovery_done), 32'd0);
  endtask

  initial begin
    bus.flush_valid  = 1'b0;
    bus.flush_robid  = '0;
    bus.flush_self   = 1'b0;
    bus.rob_head_ptr = '0;

    repeat (3) step();
    settle();
    check_quiet("reset");
    step();
    reset_n = 1'b1;
    step();
    settle();
    check_quiet("post-reset");

    run_seq("mispredict k5", 7'd3, 7'd7, 1'b0, 5);
    run_seq("exc at head", 7'd10, 7'd10, 1'b1, 0);
    run_seq("wrap k4", 7'h3E, 7'h41, 1'b0, 4);

    // Nested flush: older target 5 replaces 20, later younger flush 30 is ignored.
    step();
    bus.rob_head_ptr = 7'd2;
    drive_flush(7'd20, 1'b0);
    settle();
    check("nest T stall", 32'(bus.rename_stall), 32'd1);
    step();
    settle();
    check("nest ovw0", 32'(bus.rob_state), 32'd1);
    step();
    settle();
    check_walk("nest old walk", 7'd2, 19);
    drive_flush(7'd5, 1'b0);
    #1;
    check("nest flush stall", 32'(bus.rename_stall), 32'd1);
    step();
    settle();
    check("nest restart state", 32'(bus.rob_state), 32'd1);
    check("nest restart done",  32'(bus.recovery_done), 32'd0);
    drive_flush(7'd30, 1'b0);
    step();
    settle();
    check("nest ovw again", 32'(bus.rob_state), 32'd1);
    check("nest ovw2 done", 32'(bus.recovery_done), 32'd0);
    step();
    settle();
    check_walk("nest walk0", 7'd2, 4);
    step();
    settle();
    check_walk("nest walk1", 7'd4, 2);
    step();
    settle();
    check("nest end state", 32'(bus.rob_state), 32'd0);
    check("nest end done",  32'(bus.recovery_done), 32'd1);

    run_seq("full rob", 7'd0, 7'd63, 1'b0, 64);

    // Reset in the middle of a long walk.
    step();
    bus.rob_head_ptr = 7'd0;
    drive_flush(7'd63, 1'b0);
    step();
    step();
    step();
    settle();
    check("rst pre walk", 32'(bus.rob_state), 32'd2);
    reset_n = 1'b0;
    #1;
    check_quiet("rst async");
    step();
    settle();
    check_quiet("rst held");
    step();
    #2;
    reset_n = 1'b1;
    step();
    settle();
    check_quiet("rst released");
    step();
    settle();
    check("rst no done", 32'(bus.recovery_done), 32'd0);

    run_seq("after reset k5", 7'd3, 7'd7, 1'b0, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
